mult8_accum: RTL

MULT8_ACCUM -- requirements
Module: mult8_accum

---
 rtl/mult8_accum_pkg.sv | 13 +
 rtl/mult8_accum_outreg.sv | 84 ++++++++
 rtl/mult8_accum.sv | 124 ++++++++++++
 3 files changed

// File: rtl/mult8_accum_pkg.sv
// Shared types and constants for the mult8_accum product accumulator.
// Build macro MULT8_ACCUM_SAT_EN switches accumulation from wrapping to saturating.
package mult8_accum_pkg;
  localparam int PROD_W      = 16;
  localparam int CNT_W       = 8;
  localparam int ACC_W_DEF   = 24;
  localparam int MAX_LEN_DEF = 255;

  typedef enum logic {
    IDLE  = 1'b0,
    ACCUM = 1'b1
  } state_e;
endpackage

// File: rtl/mult8_accum_outreg.sv
// Result holding register with valid/ready handshake and sticky drop flag.
// With MULT8_ACCUM_SAT_EN defined, a per-result saturation flag is held alongside the sum.
module mult8_accum_outreg
  import mult8_accum_pkg::*;
#(
  parameter int ACC_W = ACC_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [ACC_W-1:0] load_sum,
  input  logic [CNT_W-1:0] load_cnt,
`ifdef MULT8_ACCUM_SAT_EN
  input  logic             load_sat,
  output logic             sum_sat,
`endif
  input  logic             sum_ready,
  output logic             sum_valid,
  output logic [ACC_W-1:0] sum,
  output logic [CNT_W-1:0] sum_count,
  output logic             drop
);

  logic             vld_q, vld_d;
  logic [ACC_W-1:0] sum_q, sum_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             drop_q, drop_d;
  logic             take;
`ifdef MULT8_ACCUM_SAT_EN
  logic             sat_q, sat_d;
`endif

  // A new result is accepted if the slot is empty or being emptied this cycle.
  always_comb begin
    vld_d  = vld_q;
    sum_d  = sum_q;
    cnt_d  = cnt_q;
    drop_d = drop_q;
`ifdef MULT8_ACCUM_SAT_EN
    sat_d  = sat_q;
`endif
    take   = load && (!vld_q || sum_ready);
    if (take) begin
      vld_d = 1'b1;
      sum_d = load_sum;
      cnt_d = load_cnt;
`ifdef MULT8_ACCUM_SAT_EN
      sat_d = load_sat;
`endif
    end else if (vld_q && sum_ready) begin
      vld_d = 1'b0;
    end
    if (load && !take) drop_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q  <= 1'b0;
      sum_q  <= '0;
      cnt_q  <= '0;
      drop_q <= 1'b0;
`ifdef MULT8_ACCUM_SAT_EN
      sat_q  <= 1'b0;
`endif
    end else begin
      vld_q  <= vld_d;
      sum_q  <= sum_d;
      cnt_q  <= cnt_d;
      drop_q <= drop_d;
`ifdef MULT8_ACCUM_SAT_EN
      sat_q  <= sat_d;
`endif
    end
  end

  assign sum_valid = vld_q;
  assign sum       = sum_q;
  assign sum_count = cnt_q;
  assign drop      = drop_q;
`ifdef MULT8_ACCUM_SAT_EN
  assign sum_sat   = sat_q;
`endif

endmodule

// File: rtl/mult8_accum.sv
// Batch accumulator for 8x8 multiplier products: sums products until last/MAX_LEN, then hands off.
// Define MULT8_ACCUM_SAT_EN for saturating addition and the sum_sat output.
module mult8_accum
  import mult8_accum_pkg::*;
#(
  parameter int ACC_W   = ACC_W_DEF,
  parameter int MAX_LEN = MAX_LEN_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              prod_valid,
  input  logic [PROD_W-1:0] prod,
  input  logic              prod_last,
  input  logic              clr,
  output logic              sum_valid,
  input  logic              sum_ready,
  output logic [ACC_W-1:0]  sum,
  output logic [CNT_W-1:0]  sum_count,
`ifdef MULT8_ACCUM_SAT_EN
  output logic              sum_sat,
`endif
  output logic              drop
);

  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_LEN);

`ifdef MULT8_ACCUM_SAT_EN
  function automatic logic [ACC_W:0] add_ext(input logic [ACC_W-1:0] a, input logic [PROD_W-1:0] b);
    return {1'b0, a} + {{(ACC_W + 1 - PROD_W){1'b0}}, b};
  endfunction

  function automatic logic [ACC_W-1:0] sat_clip(input logic [ACC_W:0] s);
    return s[ACC_W] ? {ACC_W{1'b1}} : s[ACC_W-1:0];
  endfunction
`else
  function automatic logic [ACC_W-1:0] wrap_add(input logic [ACC_W-1:0] a, input logic [PROD_W-1:0] b);
    return a + {{(ACC_W - PROD_W){1'b0}}, b};
  endfunction
`endif

  state_e           state_q, state_d;
  logic [ACC_W-1:0] acc_q, acc_d, acc_base, acc_next;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_base, cnt_next;
  logic             close;
`ifdef MULT8_ACCUM_SAT_EN
  logic [ACC_W:0]   sum_ext;
  logic             sat_q, sat_d, sat_next;
`endif

  // An IDLE accumulator starts from zero so a batch can open on any product.
  always_comb begin
    acc_base = (state_q == IDLE) ? '0 : acc_q;
    cnt_base = (state_q == IDLE) ? '0 : cnt_q;
    cnt_next = cnt_base + CNT_W'(1);
`ifdef MULT8_ACCUM_SAT_EN
    sum_ext  = add_ext(acc_base, prod);
    acc_next = sat_clip(sum_ext);
    sat_next = ((state_q == IDLE) ? 1'b0 : sat_q) | sum_ext[ACC_W];
`else
    acc_next = wrap_add(acc_base, prod);
`endif
    close    = prod_valid && !clr && (prod_last || (cnt_next == MAX_CNT));

    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
`ifdef MULT8_ACCUM_SAT_EN
    sat_d   = sat_q;
`endif
    if (clr || close) begin
      state_d = IDLE;
      acc_d   = '0;
      cnt_d   = '0;
`ifdef MULT8_ACCUM_SAT_EN
      sat_d   = 1'b0;
`endif
    end else if (prod_valid) begin
      state_d = ACCUM;
      acc_d   = acc_next;
      cnt_d   = cnt_next;
`ifdef MULT8_ACCUM_SAT_EN
      sat_d   = sat_next;
`endif
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      acc_q   <= '0;
      cnt_q   <= '0;
`ifdef MULT8_ACCUM_SAT_EN
      sat_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
`ifdef MULT8_ACCUM_SAT_EN
      sat_q   <= sat_d;
`endif
    end
  end

  mult8_accum_outreg #(
    .ACC_W(ACC_W)
  ) u_outreg (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (close),
    .load_sum  (acc_next),
    .load_cnt  (cnt_next),
`ifdef MULT8_ACCUM_SAT_EN
    .load_sat  (sat_next),
    .sum_sat   (sum_sat),
`endif
    .sum_ready (sum_ready),
    .sum_valid (sum_valid),
    .sum       (sum),
    .sum_count (sum_count),
    .drop      (drop)
  );

endmodule
